// File: rtl/pio_pkg.sv
// Shared window layout and address-decode helpers for the parallel I/O bank.
// Offsets are relative to BASE_ADDR: OUT ports, then IN ports, then STATUS and MASK.
package pio_pkg;

  typedef enum logic [1:0] {
    REG_OUT,
    REG_IN,
    REG_STATUS,
    REG_MASK
  } regKind_e;

  function automatic int unsigned pioOffStatus(input int unsigned nOut, input int unsigned nIn);
    return nOut + nIn;
  endfunction

  function automatic int unsigned pioOffMask(input int unsigned nOut, input int unsigned nIn);
    return nOut + nIn + 1;
  endfunction

  function automatic int unsigned pioWinLen(input int unsigned nOut, input int unsigned nIn);
    return nOut + nIn + 2;
  endfunction

  // Evaluated in 32 bits so a window ending at the top of the address space cannot wrap.
  function automatic logic pioHit(input logic [31:0] addr, input logic [31:0] base,
                                  input logic [31:0] winLen);
    return (addr >= base) && (addr < base + winLen);
  endfunction

  function automatic regKind_e pioKind(input logic [31:0] off, input int unsigned nOut,
                                       input int unsigned nIn);
    if (off < nOut) return REG_OUT;
    if (off < nOut + nIn) return REG_IN;
    if (off == nOut + nIn) return REG_STATUS;
    return REG_MASK;
  endfunction

endpackage

// File: rtl/pio_in_sync.sv
// Per-port input synchroniser: two flops into the clock domain, plus a "previous" flop
// for change detection when PIO_CHANGE_IRQ_EN is defined.
module pio_in_sync #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] sync_o
`ifdef PIO_CHANGE_IRQ_EN
  ,
  output logic              change_o
`endif
);

  logic [DATA_W-1:0] meta_q;
  logic [DATA_W-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

`ifdef PIO_CHANGE_IRQ_EN
  logic [DATA_W-1:0] prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= '0;
    else     prev_q <= sync_q;
  end

  assign change_o = (sync_q != prev_q);
`endif

endmodule

// File: rtl/parallel_io_bank.sv
// Memory-mapped parallel I/O bank: N_OUT output registers, N_IN synchronised inputs and,
// with PIO_CHANGE_IRQ_EN defined, change STATUS (W1C), MASK and a registered irq.
module parallel_io_bank
  import pio_pkg::*;
#(
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       ADDR_W    = 8,
  parameter int unsigned       N_OUT     = 2,
  parameter int unsigned       N_IN      = 2,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 8'hF0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [DATA_W-1:0]       wdata,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic [DATA_W-1:0]       rdata,
  output logic                    io_hit,
  input  logic [N_IN*DATA_W-1:0]  pin_in,
  output logic [N_OUT*DATA_W-1:0] pin_out,
  output logic                    irq
);

  localparam int unsigned WIN_LEN = pioWinLen(N_OUT, N_IN);

  logic [31:0]                   offset;
  regKind_e                      regKind;
  logic [N_OUT-1:0][DATA_W-1:0]  out_q;
  logic [N_OUT-1:0][DATA_W-1:0]  out_d;
  logic [N_IN-1:0][DATA_W-1:0]   syncVal;

  assign offset  = 32'(addr) - 32'(BASE_ADDR);
  assign io_hit  = pioHit(32'(addr), 32'(BASE_ADDR), WIN_LEN);
  assign regKind = pioKind(offset, N_OUT, N_IN);
  assign pin_out = out_q;

`ifdef PIO_CHANGE_IRQ_EN
  logic [N_IN-1:0] change;
`endif

  for (genvar k = 0; k < N_IN; k++) begin : gIn
    pio_in_sync #(.DATA_W(DATA_W)) uSync (
      .clk     (clk),
      .rst     (rst),
      .d_i     (pin_in[k*DATA_W +: DATA_W]),
      .sync_o  (syncVal[k])
`ifdef PIO_CHANGE_IRQ_EN
      ,
      .change_o(change[k])
`endif
    );
  end

  always_comb begin
    out_d = out_q;
    if (we && io_hit && regKind == REG_OUT) begin
      for (int k = 0; k < N_OUT; k++) begin
        if (offset == 32'(k)) out_d[k] = wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_q <= '0;
    else     out_q <= out_d;
  end

`ifdef PIO_CHANGE_IRQ_EN
  localparam logic [DATA_W-1:0] IN_BITS = DATA_W'((64'd1 << N_IN) - 64'd1);

  logic [DATA_W-1:0] status_q, status_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  logic              irq_q, irq_d;

  // The change term is OR-ed in last so a simultaneous W1C never hides a new change.
  always_comb begin
    status_d = status_q;
    mask_d   = mask_q;
    if (we && io_hit && regKind == REG_STATUS) status_d = status_q & ~(wdata & IN_BITS);
    if (we && io_hit && regKind == REG_MASK)   mask_d   = wdata & IN_BITS;
    status_d = status_d | DATA_W'(change);
    irq_d    = |(status_q & mask_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q <= '0;
      mask_q   <= '0;
      irq_q    <= 1'b0;
    end else begin
      status_q <= status_d;
      mask_q   <= mask_d;
      irq_q    <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rdata = mem_rdata;
    if (io_hit) begin
      rdata = '0;
      case (regKind)
        REG_OUT: begin
          for (int k = 0; k < N_OUT; k++) begin
            if (offset == 32'(k)) rdata = out_q[k];
          end
        end
        REG_IN: begin
          for (int k = 0; k < N_IN; k++) begin
            if (offset == 32'(N_OUT) + 32'(k)) rdata = syncVal[k];
          end
        end
`ifdef PIO_CHANGE_IRQ_EN
        REG_STATUS: rdata = status_q;
        REG_MASK:   rdata = mask_q;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_parallel_io_bank.sv
// Scoreboard bench for parallel_io_bank (default parameters); tracks PIO_CHANGE_IRQ_EN.
// Expected values come from a delay-history model of the I/O window.
module tb_parallel_io_bank;

  localparam int NO = 2;
  localparam int NI = 2;
  localparam int BASE = 'hF0;
`ifdef PIO_CHANGE_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  localparam logic [1:0] K_RDATA = 2'd0, K_HIT = 2'd1, K_PINOUT = 2'd2, K_IRQ = 2'd3;

  logic        clk = 1'b0;
  logic        rst, we, ioHit, irq;
  logic [7:0]  addr, wdata, memRdata, rdata;
  logic [15:0] pinIn, pinOut;

  always #5 clk = ~clk;

  parallel_io_bank #(
    .DATA_W(8), .ADDR_W(8), .N_OUT(NO), .N_IN(NI), .BASE_ADDR(8'hF0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .mem_rdata(memRdata),
    .rdata    (rdata),
    .io_hit   (ioHit),
    .pin_in   (pinIn),
    .pin_out  (pinOut),
    .irq      (irq)
  );

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] exp;
  } expItem_t;

  expItem_t    expQ[$];
  int          vectors = 0;
  int          miscompares = 0;

  logic [7:0]  outM[NO];
  logic [7:0]  statusM, maskM;
  logic        irqM;
  logic [15:0] samp[$];

  function automatic logic inWin(input logic [7:0] a);
    return (int'(a) >= BASE) && (int'(a) < BASE + NO + NI + 2);
  endfunction

  // samp holds pin_in as sampled at the last three edges, oldest first.
  function automatic logic [7:0] expRead(input logic [7:0] a, input logic [7:0] m);
    int          off;
    logic [15:0] inNow;
    if (!inWin(a)) return m;
    off = int'(a) - BASE;
    if (off < NO) return outM[off];
    if (off < NO + NI) begin
      inNow = samp[1];
      return inNow[(off-NO)*8 +: 8];
    end
    if (!IRQ_EN) return 8'h00;
    if (off == NO + NI) return statusM;
    return maskM;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < NO; k++) outM[k] = 8'h00;
    statusM = 8'h00;
    maskM   = 8'h00;
    irqM    = 1'b0;
    samp    = '{16'h0, 16'h0, 16'h0};
  endtask

  task automatic modelEdge();
    logic [7:0]  setB, clrB;
    logic [15:0] s0, s1;
    int          off;
    setB = 8'h00;
    clrB = 8'h00;
    s0 = samp[0];
    s1 = samp[1];
    for (int k = 0; k < NI; k++) if (s1[k*8 +: 8] != s0[k*8 +: 8]) setB[k] = 1'b1;
    if (IRQ_EN) irqM = |(statusM & maskM);
    if (we && inWin(addr)) begin
      off = int'(addr) - BASE;
      if (off < NO) outM[off] = wdata;
      else if (off == NO + NI) clrB = wdata;
      else if (off == NO + NI + 1 && IRQ_EN) maskM = wdata & 8'h03;
    end
    if (IRQ_EN) statusM = (statusM & ~clrB) | setB;
    samp.push_back(pinIn);
    void'(samp.pop_front());
  endtask

  task automatic pushItem(input logic [1:0] k, input logic [31:0] v);
    expItem_t it;
    it.kind = k;
    it.exp  = v;
    expQ.push_back(it);
  endtask

  task automatic pushExpected();
    pushItem(K_RDATA, {24'h0, expRead(addr, memRdata)});
    pushItem(K_HIT, {31'h0, inWin(addr)});
    pushItem(K_PINOUT, {16'h0, outM[1], outM[0]});
    pushItem(K_IRQ, {31'h0, irqM});
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) modelReset();
    else     modelEdge();
    #1;
  endtask

  task automatic driveOnly(input logic w, input logic [7:0] a, input logic [7:0] d,
                           input logic [15:0] p, input logic [7:0] m);
    we = w; addr = a; wdata = d; pinIn = p; memRdata = m;
  endtask

  task automatic applyStimulus(input logic w, input logic [7:0] a, input logic [7:0] d,
                               input logic [15:0] p, input logic [7:0] m);
    driveOnly(w, a, d, p, m);
    pushExpected();
  endtask

  task automatic checkOutput(input expItem_t it);
    logic [31:0] act;
    string       nm;
    case (it.kind)
      K_RDATA:  begin act = {24'h0, rdata};  nm = "rdata";   end
      K_HIT:    begin act = {31'h0, ioHit};  nm = "io_hit";  end
      K_PINOUT: begin act = {16'h0, pinOut}; nm = "pin_out"; end
      default:  begin act = {31'h0, irq};    nm = "irq";     end
    endcase
    vectors++;
    if (act !== it.exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", nm, $time, act, it.exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      while (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: bench did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] p;
    logic [7:0]  a;
    rst = 1'b1;
    driveOnly(1'b0, 8'h10, 8'h00, 16'h0000, 8'hA5);
    modelReset();
    #1;
    pushExpected();
    pushItem(K_PINOUT, 32'h0);
    pushItem(K_IRQ, 32'h0);
    repeat (2) begin
      tick();
      applyStimulus(1'b0, 8'h10, 8'h00, 16'h0000, 8'hA5);
    end
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 8'h10, 8'h00, 16'h0000, 8'hA5);
    pushItem(K_RDATA, 32'hA5);
    pushItem(K_HIT, 32'h0);

    // Output write, readback, and an ignored write to an input port.
    tick(); applyStimulus(1'b1, 8'hF1, 8'h3C, 16'h0000, 8'h77);
    tick(); applyStimulus(1'b0, 8'hF1, 8'h00, 16'h0000, 8'h77);
    pushItem(K_RDATA, 32'h3C);
    pushItem(K_PINOUT, 32'h3C00);
    tick(); applyStimulus(1'b1, 8'hF2, 8'h55, 16'h0000, 8'h77);
    tick(); applyStimulus(1'b0, 8'hF2, 8'h00, 16'h0000, 8'h77);
    pushItem(K_RDATA, 32'h00);
    pushItem(K_PINOUT, 32'h3C00);

    // Input change: visible after 2 edges, STATUS after 3, no irq while masked.
    tick(); applyStimulus(1'b0, 8'hF2, 8'h00, 16'h0081, 8'h00);
    tick(); applyStimulus(1'b0, 8'hF2, 8'h00, 16'h0081, 8'h00);
    pushItem(K_RDATA, 32'h00);
    tick(); applyStimulus(1'b0, 8'hF2, 8'h00, 16'h0081, 8'h00);
    pushItem(K_RDATA, 32'h81);
    tick(); applyStimulus(1'b0, 8'hF4, 8'h00, 16'h0081, 8'h00);
    pushItem(K_RDATA, IRQ_EN ? 32'h01 : 32'h00);
    tick(); applyStimulus(1'b0, 8'hF4, 8'h00, 16'h0081, 8'h00);
    pushItem(K_IRQ, 32'h0);

    // Clear, unmask port 0, then a toggle must raise irq on the fourth edge.
    tick(); applyStimulus(1'b1, 8'hF4, 8'h01, 16'h0081, 8'h00);
    tick(); applyStimulus(1'b1, 8'hF5, 8'h01, 16'h0081, 8'h00);
    tick(); applyStimulus(1'b0, 8'hF5, 8'h00, 16'h0081, 8'h00);
    pushItem(K_RDATA, IRQ_EN ? 32'h01 : 32'h00);
    tick(); applyStimulus(1'b0, 8'hF0, 8'h00, 16'h0080, 8'h00);
    for (int e = 1; e <= 4; e++) begin
      tick(); applyStimulus(1'b0, 8'hF4, 8'h00, 16'h0080, 8'h00);
      pushItem(K_IRQ, (e == 4 && IRQ_EN) ? 32'h1 : 32'h0);
    end
    tick(); applyStimulus(1'b1, 8'hF4, 8'h01, 16'h0080, 8'h00);
    tick(); applyStimulus(1'b0, 8'hF4, 8'h00, 16'h0080, 8'h00);
    pushItem(K_RDATA, 32'h00);
    tick(); applyStimulus(1'b0, 8'hF4, 8'h00, 16'h0080, 8'h00);
    pushItem(K_IRQ, 32'h0);

    // Set STATUS[0], then land a W1C on the very edge a new change is detected.
    tick(); applyStimulus(1'b0, 8'hF4, 8'h00, 16'h0081, 8'h00);
    repeat (3) begin tick(); applyStimulus(1'b0, 8'hF4, 8'h00, 16'h0081, 8'h00); end
    applyStimulus(1'b0, 8'hF4, 8'h00, 16'h0080, 8'h00);
    tick(); applyStimulus(1'b0, 8'hF4, 8'h00, 16'h0080, 8'h00);
    tick(); applyStimulus(1'b1, 8'hF4, 8'h01, 16'h0080, 8'h00);
    tick(); applyStimulus(1'b0, 8'hF4, 8'h00, 16'h0080, 8'h00);
    pushItem(K_RDATA, IRQ_EN ? 32'h01 : 32'h00);

    // Asynchronous reset mid-cycle, checked before the next clock edge.
    tick();
    driveOnly(1'b0, 8'hF4, 8'h00, 16'h0080, 8'h00);
    #1;
    rst = 1'b1;
    modelReset();
    pushExpected();
    pushItem(K_PINOUT, 32'h0);
    pushItem(K_IRQ, 32'h0);
    pushItem(K_RDATA, 32'h0);
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 8'hF1, 8'h00, 16'h0080, 8'h00);

    p = 16'h0080;
    for (int i = 0; i < 400; i++) begin
      tick();
      if ($urandom_range(0, 9) < 8) a = 8'(BASE + $urandom_range(0, NO + NI + 1));
      else                          a = 8'($urandom);
      if ($urandom_range(0, 3) == 0) p = 16'($urandom);
      applyStimulus(1'($urandom_range(0, 1)), a, 8'($urandom), p, 8'($urandom));
    end

    tick();
    driveOnly(1'b0, 8'h00, 8'h00, p, 8'h00);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/parallel_io_bank.md
# parallel_io_bank

Parametrised memory-mapped parallel I/O bank for the single-cycle 8-bit RISC-V datapath. It replaces the single-register output and single-input read path with N_OUT writable output ports and N_IN synchronised input ports, plus per-port change detection and an interrupt line. It sits beside DATA_MEMORY on the ALU-result address bus. Its read data is muxed ahead of the ResultSrc mux.

## Interface
Parameters:
- DATA_W, 8, width of each port and of the data bus
- ADDR_W, 8, address bus width
- N_OUT, 2, number of output ports (1..8)
- N_IN, 2, number of input ports (1..DATA_W)
- BASE_ADDR, 8'hF0, first address of the I/O window; BASE_ADDR+N_OUT+N_IN+2 must be ≤ 2^ADDR_W

Ports (all single clock domain):
- clk, in, 1, processor clock
- rst, in, 1, asynchronous, active-high reset
- we, in, 1, store strobe (MemWrite)
- addr, in, ADDR_W, byte address (ALU result)
- wdata, in, DATA_W, store data (rd2)
- mem_rdata, in, DATA_W, DATA_MEMORY read data
- rdata, out, DATA_W, read data to the result mux
- io_hit, out, 1, addr falls inside the I/O window
- pin_in, in, N_IN*DATA_W, asynchronous external inputs; port k occupies [k*DATA_W +: DATA_W]
- pin_out, out, N_OUT*DATA_W, registered outputs; same packing as pin_in
- irq, out, 1, level interrupt request

## Operation
Window offsets, relative to BASE_ADDR:
- 0..N_OUT-1: OUT[k], read/write
- N_OUT..N_OUT+N_IN-1: IN[k], read-only, synchronised value
- N_OUT+N_IN: STATUS, bit k = change seen on IN[k]; write-1-to-clear
- N_OUT+N_IN+1: MASK, read/write; bit k enables STATUS[k] onto irq

Address decode and read path:
- io_hit = (addr ≥ BASE_ADDR) && (addr < BASE_ADDR+N_OUT+N_IN+2). Compare in ADDR_W+1 bits so the window never wraps.
- rdata = io_hit ? selected register : mem_rdata.
- Reads are purely combinational and have no side effects.
- Unused STATUS/MASK bits (index ≥ N_IN) read 0 and ignore writes.

Write behaviour:
- A write to an IN offset is ignored.
- Writes with io_hit=0 are ignored by this block.
- DATA_MEMORY still receives every store; gating the store is the top level's job.

Input path:
- Each IN port has a 2-flop synchroniser followed by a third "previous" flop.
- change[k] = sync[k] ≠ prev[k], i.e. any bit differs.
- STATUS[k] is set on a change.

irq = |(STATUS & MASK), registered.

## Timing
Reset values:
- pin_out, sync, prev, STATUS, MASK and irq all reset to 0.
- rdata follows mem_rdata whenever io_hit=0.

Latencies:
- OUT write: pin_out updates on the clk edge that samples we=1. Readback is valid in the following cycle.
- pin_in change → visible through IN[k] after 2 edges.
- pin_in change → STATUS[k]=1 after 3 edges.
- pin_in change → irq=1 after 4 edges (if the MASK bit is set).

Boundary rules:
- A change and a W1C clear of the same STATUS bit in the same cycle: set wins and the bit stays 1.
- A MASK write takes effect on irq one edge later.
- A reset asserted mid-operation clears everything immediately.
- After reset release, prev=sync=0. An input held non-zero through reset therefore raises STATUS 3 edges after release; this is intended.

## Configuration
Macro: PIO_CHANGE_IRQ_EN.
- Defined: STATUS, MASK, the prev flops and irq are implemented as described above.
- Undefined: the STATUS and MASK offsets read 0 and ignore writes; irq is tied to 0; the prev flops are not built. The window length is unchanged so software addresses stay fixed.

## Structure
- Package pio_pkg: offset constants computed from the parameters (OFF_STATUS, OFF_MASK, WIN_LEN) and a function computing io_hit from addr and base.
- Sub-module pio_in_sync: one instance per input port, holding the 2-flop synchroniser plus the prev flop. Outputs: sync value and change pulse.
- All other logic, including register decode, the read mux and irq, lives in the top block.

## Test plan
All scenarios use the default parameters (out F0/F1, in F2/F3, STATUS F4, MASK F5).
1. Reset with rst=1, then release → pin_out=0, irq=0; read at addr 8'h10 returns mem_rdata=8'hA5 with io_hit=0.
2. Write 8'h3C to F1 → pin_out[15:8]=8'h3C on the next edge; reading F1 returns 8'h3C; pin_out[7:0] stays 0. Write to F2 → no state change.
3. Drive pin_in[7:0]=8'h81 → reading F2 returns 8'h81 after 2 edges; STATUS=8'h01 after 3 edges; irq stays 0 (MASK=0).
4. Write MASK F5=8'h01, toggle pin_in[7:0] → irq=1 four edges after the toggle. Write 8'h01 to F4 → STATUS=0 and irq=0 one edge later.
5. A W1C of bit 0 issued in the exact cycle a new change is detected on port 0 → STATUS[0] stays 1.
6. Assert rst mid-sequence (pin_out=8'h3C, STATUS=8'h01) → all outputs read 0 asynchronously, before the next clk edge. With PIO_CHANGE_IRQ_EN undefined, re-run scenario 3 → F4 reads 0 and irq stays 0.
